rggen_indirect_access_sequencer: RTL and testbench
==================================================

// Module: rggen_indirect_access_sequencer
// PURPOSE
//  Converts one-shot indirect requests (index + read/write) into two register-bus transactions.
//  First it writes the index register at INDEX_ADDRESS; then it accesses the indirect data window at DATA_ADDRESS.
//  Sits between a host-side command source and the register bus that feeds rggen_register_if.
//  One request in flight; the response is returned on a valid/ready channel.
// PARAMETERS
//  ADDRESS_WIDTH  8    register bus address width
//  BUS_WIDTH      32   register bus data width (multiple of 8)
//  INDEX_WIDTH    1    indirect index width (<= BUS_WIDTH - INDEX_LSB)
//  INDEX_LSB      0    bit position of the index field inside the index register
//  INDEX_ADDRESS  '0   byte address of the index register
//  DATA_ADDRESS   '0   byte address of the indirect data register
// PORTS
//  i_clk            in   1            clock
//  i_rst_n          in   1            reset; synchronous, active-low
//  i_req_valid      in   1            request valid
//  o_req_ready      out  1            request accepted when valid & ready
//  i_req_write      in   1            1 = write, 0 = read
//  i_req_index      in   INDEX_WIDTH  indirect index
//  i_req_data       in   BUS_WIDTH    write data
//  i_req_strobe     in   BUS_WIDTH/8  write byte strobe
//  o_bus_valid      out  1            bus access valid
//  i_bus_ready      in   1            bus access done this cycle
//  o_bus_write      out  1            bus access type
//  o_bus_address    out  ADDRESS_WIDTH bus address
//  o_bus_write_data out  BUS_WIDTH    bus write data
//  o_bus_strobe     out  BUS_WIDTH/8  bus byte strobe
//  i_bus_status     in   2            bus status: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
//  i_bus_read_data  in   BUS_WIDTH    bus read data
//  o_rsp_valid      out  1            response valid
//  i_rsp_ready      in   1            response consumed when valid & ready
//  o_rsp_status     out  2            final status
//  o_rsp_data       out  BUS_WIDTH    read data; 0 for writes and on index-phase error
// BEHAVIOUR
//  - Reset (i_rst_n==0 at a clock edge): state IDLE; o_req_ready=1; o_bus_valid=0; o_rsp_valid=0.
//    All data/address/status outputs are 0; the index cache is invalid.
//  - Reset mid-operation: the transaction is abandoned and no response is produced.
//    The bus may see o_bus_valid drop before ready; that is acceptable.
//  - FSM states and transitions:
//    - IDLE -> INDEX_WR on accept. The request is registered.
//    - INDEX_WR: o_bus_valid=1, write, INDEX_ADDRESS.
//      Write data = index << INDEX_LSB, strobe all ones.
//    - INDEX_WR -> DATA_ACC on ready with status OKAY or EXOKAY.
//    - INDEX_WR -> RESP on ready with an error status. That error is reported and no data access occurs.
//    - DATA_ACC: o_bus_valid=1, DATA_ADDRESS, registered type, data and strobe.
//      For reads, the strobe is 0 and the write data is 0.
//    - DATA_ACC -> RESP on ready. The bus status and read data are captured.
//    - RESP: o_rsp_valid=1 until i_rsp_ready. Then -> IDLE.
//  - o_req_ready=1 only in IDLE. A request cannot be accepted in the same cycle as a response handshake.
//  - o_bus_valid is held, with stable address/data, until i_bus_ready. The bus is never idle-valid outside INDEX_WR/DATA_ACC.
//  - Latency with zero-wait bus, no cache: accept at cycle 0; index access at cycle 1; data access at cycle 2; o_rsp_valid at cycle 3.
//  - Each bus wait state adds 1 cycle per phase.
// CONFIGURATION
//  - RGGEN_INDIRECT_INDEX_CACHE_EN defined: a last-index register plus a valid bit are kept.
//    - On accept, if valid and i_req_index == last index, IDLE -> DATA_ACC directly. Latency becomes 2 cycles.
//    - The cache is updated on an OKAY or EXOKAY index write.
//    - The cache is invalidated on an index-phase error and on reset.
//  - Not defined: every request performs the index write. No cache flops exist.
// STRUCTURE
//  - Package rggen_indirect_sequencer_pkg holds:
//    - the state enum (IDLE, INDEX_WR, DATA_ACC, RESP)
//    - status constants OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR
//    - the helper function is_error(status)
//  - Single module, no sub-module; request and response holding registers are inline.
// TESTING
//  1. Write idx=1, data=32'hA5A5_0F0F, strobe=4'hF, zero-wait bus -> bus sees:
//     - write @INDEX_ADDRESS with data 32'h1
//     - then write @DATA_ADDRESS with data A5A5_0F0F
//     - then rsp OKAY with data 0, valid at cycle 3.
//  2. Read idx=0, bus returns 32'h1234_5678 after 2 wait states per phase -> o_rsp_data=32'h1234_5678, valid at cycle 7.
//     o_bus_valid and o_bus_address stay stable through the waits.
//  3. Index write returns SLAVE_ERROR -> no DATA_ADDRESS access; rsp status=2'b10, data=0.
//  4. Response back-pressure: i_rsp_ready low for 5 cycles -> o_rsp_valid and data held, o_req_ready=0 throughout.
//     The next request is accepted only after the response handshake.
//  5. Cache enabled: two reads at idx=1 back to back -> the second skips the index write and responds at cycle 2.
//     A read at idx=0 then performs the index write.
//  6. Reset asserted during DATA_ACC -> the next cycle has o_bus_valid=0, o_rsp_valid=0 and o_req_ready=1.
//     With cache enabled, the next request performs the index write.

Source files
------------

// File: rtl/rggen_indirect_access_sequencer_pkg.sv
// Shared types and constants for the indirect access sequencer:
// FSM state encoding, register-bus status codes and an error helper.
package rggen_indirect_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INDEX_WR,
    DATA_ACC,
    RESP
  } state_e;

  localparam logic [1:0] STATUS_OKAY         = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  // Both error codes have the MSB set; OKAY and EXOKAY do not.
  function automatic logic is_error(input logic [1:0] status);
    return status[1];
  endfunction

endpackage

// File: rtl/rggen_indirect_access_sequencer_if.sv
// Request, register-bus and response channels of the indirect access
// sequencer. The master modport is the sequencer's view; the slave modport
// is the surrounding environment (command source, bus, response sink).
interface rggen_indirect_access_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int INDEX_WIDTH   = 1
);

  // request channel
  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_write;
  logic [INDEX_WIDTH-1:0]   i_req_index;
  logic [BUS_WIDTH-1:0]     i_req_data;
  logic [BUS_WIDTH/8-1:0]   i_req_strobe;

  // register bus
  logic                     o_bus_valid;
  logic                     i_bus_ready;
  logic                     o_bus_write;
  logic [ADDRESS_WIDTH-1:0] o_bus_address;
  logic [BUS_WIDTH-1:0]     o_bus_write_data;
  logic [BUS_WIDTH/8-1:0]   o_bus_strobe;
  logic [1:0]               i_bus_status;
  logic [BUS_WIDTH-1:0]     i_bus_read_data;

  // response channel
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [1:0]               o_rsp_status;
  logic [BUS_WIDTH-1:0]     o_rsp_data;

  modport master (
    input  i_req_valid, i_req_write, i_req_index, i_req_data, i_req_strobe,
    output o_req_ready,
    output o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe,
    input  i_bus_ready, i_bus_status, i_bus_read_data,
    output o_rsp_valid, o_rsp_status, o_rsp_data,
    input  i_rsp_ready
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_index, i_req_data, i_req_strobe,
    input  o_req_ready,
    input  o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe,
    output i_bus_ready, i_bus_status, i_bus_read_data,
    input  o_rsp_valid, o_rsp_status, o_rsp_data,
    output i_rsp_ready
  );

endinterface

// File: rtl/rggen_indirect_access_sequencer.sv
// Indirect access sequencer: turns one indirect request (index + read/write)
// into an index-register write followed by a data-window access, then
// returns the final status/data on a valid/ready response channel.
// Optional feature macro: RGGEN_INDIRECT_INDEX_CACHE_EN -- remembers the last
// successfully written index and skips the index write when it repeats.
module rggen_indirect_access_sequencer
  import rggen_indirect_sequencer_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       BUS_WIDTH     = 32,
  parameter int                       INDEX_WIDTH   = 1,
  parameter int                       INDEX_LSB     = 0,
  parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = '0,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = '0
) (
  input logic                               i_clk,
  input logic                               i_rst_n,
  rggen_indirect_access_sequencer_if.master seq_if
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  state_e                  state_q, state_d;
  logic                    req_write_q, req_write_d;
  logic [INDEX_WIDTH-1:0]  req_index_q, req_index_d;
  logic [BUS_WIDTH-1:0]    req_data_q, req_data_d;
  logic [STRB_WIDTH-1:0]   req_strobe_q, req_strobe_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic [BUS_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                    index_hit;
  logic                    index_ok;
  logic [BUS_WIDTH-1:0]    index_word;

  // Index register value: the index placed at its field position.
  assign index_word = BUS_WIDTH'(req_index_q) << INDEX_LSB;

  // The index write completed without error this cycle.
  assign index_ok = (state_q == INDEX_WR) && seq_if.i_bus_ready &&
                    !is_error(seq_if.i_bus_status);

`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
  logic                   cache_valid_q, cache_valid_d;
  logic [INDEX_WIDTH-1:0] cache_index_q, cache_index_d;

  assign index_hit = cache_valid_q && (seq_if.i_req_index == cache_index_q);

  // Cache update: learn on a good index write, forget on an index error.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_index_d = cache_index_q;
    if (index_ok) begin
      cache_valid_d = 1'b1;
      cache_index_d = req_index_q;
    end else if ((state_q == INDEX_WR) && seq_if.i_bus_ready) begin
      cache_valid_d = 1'b0;
    end
  end

  // Cache registers; reset invalidates the remembered index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cache_valid_q <= 1'b0;
      cache_index_q <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_index_q <= cache_index_d;
    end
  end
`else
  assign index_hit = 1'b0;
`endif

  // Next-state and holding-register update for the request/response flow.
  always_comb begin
    // NOTE: every signal gets its default first so no branch can leave one
    // unassigned, which would infer a latch.
    state_d      = state_q;
    req_write_d  = req_write_q;
    req_index_d  = req_index_q;
    req_data_d   = req_data_q;
    req_strobe_d = req_strobe_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (seq_if.i_req_valid) begin
          req_write_d  = seq_if.i_req_write;
          req_index_d  = seq_if.i_req_index;
          // Reads put zero data and strobe on the bus, so store them that way.
          req_data_d   = seq_if.i_req_write ? seq_if.i_req_data   : '0;
          req_strobe_d = seq_if.i_req_write ? seq_if.i_req_strobe : '0;
          state_d      = index_hit ? DATA_ACC : INDEX_WR;
        end
      end
      INDEX_WR: begin
        if (seq_if.i_bus_ready) begin
          if (index_ok) begin
            state_d = DATA_ACC;
          end else begin
            // The data window would address the wrong entry; report and stop.
            state_d      = RESP;
            rsp_status_d = seq_if.i_bus_status;
            rsp_data_d   = '0;
          end
        end
      end
      DATA_ACC: begin
        if (seq_if.i_bus_ready) begin
          state_d      = RESP;
          rsp_status_d = seq_if.i_bus_status;
          rsp_data_d   = req_write_q ? '0 : seq_if.i_bus_read_data;
        end
      end
      RESP: begin
        if (seq_if.i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: bus and response signals are driven only in their states.
  always_comb begin
    seq_if.o_req_ready      = (state_q == IDLE);
    seq_if.o_bus_valid      = 1'b0;
    seq_if.o_bus_write      = 1'b0;
    seq_if.o_bus_address    = '0;
    seq_if.o_bus_write_data = '0;
    seq_if.o_bus_strobe     = '0;
    seq_if.o_rsp_valid      = 1'b0;
    seq_if.o_rsp_status     = '0;
    seq_if.o_rsp_data       = '0;

    unique case (state_q)
      INDEX_WR: begin
        seq_if.o_bus_valid      = 1'b1;
        seq_if.o_bus_write      = 1'b1;
        seq_if.o_bus_address    = INDEX_ADDRESS;
        seq_if.o_bus_write_data = index_word;
        seq_if.o_bus_strobe     = '1;
      end
      DATA_ACC: begin
        seq_if.o_bus_valid      = 1'b1;
        seq_if.o_bus_write      = req_write_q;
        seq_if.o_bus_address    = DATA_ADDRESS;
        seq_if.o_bus_write_data = req_data_q;
        seq_if.o_bus_strobe     = req_strobe_q;
      end
      RESP: begin
        seq_if.o_rsp_valid  = 1'b1;
        seq_if.o_rsp_status = rsp_status_q;
        seq_if.o_rsp_data   = rsp_data_q;
      end
      default: ;
    endcase
  end

  // State and holding registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the payload registers are reset as well, so everything derived
      // from them reads zero straight out of reset.
      state_q      <= IDLE;
      req_write_q  <= 1'b0;
      req_index_q  <= '0;
      req_data_q   <= '0;
      req_strobe_q <= '0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      req_write_q  <= req_write_d;
      req_index_q  <= req_index_d;
      req_data_q   <= req_data_d;
      req_strobe_q <= req_strobe_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_rggen_indirect_access_sequencer.sv
// Directed testbench for rggen_indirect_access_sequencer. Expected values are
// hand-computed; cache expectations follow RGGEN_INDIRECT_INDEX_CACHE_EN.
module tb_rggen_indirect_access_sequencer;
  import rggen_indirect_sequencer_pkg::*;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int IW = 2;
  localparam int SW = BW / 8;
  localparam logic [AW-1:0] IDX_ADDR = 8'h10;
  localparam logic [AW-1:0] DAT_ADDR = 8'h14;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rggen_indirect_access_sequencer_if #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .INDEX_WIDTH(IW)
  ) bif ();

  rggen_indirect_access_sequencer #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .INDEX_WIDTH(IW), .INDEX_LSB(0),
    .INDEX_ADDRESS(IDX_ADDR), .DATA_ADDRESS(DAT_ADDR)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .seq_if  (bif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus slave model: per-phase wait states, status chosen by address.
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [SW-1:0] strobe;
  } acc_t;

  acc_t       log_q[$];
  int         bus_waits = 0;
  logic [1:0] idx_status = STATUS_OKAY;
  logic [1:0] dat_status = STATUS_OKAY;
  logic [BW-1:0] rd_data = '0;

  initial begin
    bit   in_acc;
    int   wait_cnt;
    acc_t cur;
    in_acc = 1'b0;
    wait_cnt = 0;
    bif.i_bus_ready = 1'b0;
    bif.i_bus_status = 2'b11;
    bif.i_bus_read_data = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bif.o_bus_valid) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          wait_cnt = 0;
          cur = '{bif.o_bus_write, bif.o_bus_address, bif.o_bus_write_data, bif.o_bus_strobe};
        end else begin
          check("bus_addr_stable", bif.o_bus_address, cur.addr);
          check("bus_wdata_stable", bif.o_bus_write_data, cur.data);
        end
        if (wait_cnt == bus_waits) begin
          bif.i_bus_ready = 1'b1;
          bif.i_bus_status = (cur.addr == IDX_ADDR) ? idx_status : dat_status;
          bif.i_bus_read_data = rd_data;
          log_q.push_back(cur);
          in_acc = 1'b0;
        end else begin
          bif.i_bus_ready = 1'b0;
          bif.i_bus_status = 2'b11;
          bif.i_bus_read_data = 32'hBAD0_BAD0;
          wait_cnt++;
        end
      end else begin
        bif.i_bus_ready = 1'b0;
        bif.i_bus_status = 2'b11;
        bif.i_bus_read_data = 32'hBAD0_BAD0;
        in_acc = 1'b0;
      end
    end
  end

  task automatic check_acc(input string tag, input int i, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] dt,
                           input logic [SW-1:0] sb);
    check({tag, "_present"}, i < log_q.size(), 1);
    if (i < log_q.size()) begin
      check({tag, "_write"}, log_q[i].write, wr);
      check({tag, "_addr"}, log_q[i].addr, a);
      check({tag, "_data"}, log_q[i].data, dt);
      check({tag, "_strobe"}, log_q[i].strobe, sb);
    end
  endtask

  // Present a request at a negedge; returns the cycle number of acceptance.
  task automatic send_req(input logic wr, input logic [IW-1:0] idx,
                          input logic [BW-1:0] data, input logic [SW-1:0] strb,
                          output int acc_cyc);
    int n = 0;
    bif.i_req_valid = 1'b1;
    bif.i_req_write = wr;
    bif.i_req_index = idx;
    bif.i_req_data = data;
    bif.i_req_strobe = strb;
    while (!bif.o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_in_time", n < 50, 1);
    acc_cyc = cyc;
    @(negedge clk);
    bif.i_req_valid = 1'b0;
    bif.i_req_write = ~wr;
    bif.i_req_index = ~idx;
    bif.i_req_data = ~data;
    bif.i_req_strobe = ~strb;
  endtask

  // Wait for the response, optionally back-pressure it, then consume it.
  task automatic wait_rsp(input int acc_cyc, input int bp_cycles, input bit hold_req,
                          output logic [1:0] st, output logic [BW-1:0] d, output int lat);
    int n = 0;
    while (!bif.o_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_in_time", n < 100, 1);
    lat = cyc - acc_cyc;
    st = bif.o_rsp_status;
    d = bif.o_rsp_data;
    if (hold_req) bif.i_req_valid = 1'b1;
    for (int i = 0; i < bp_cycles; i++) begin
      check("bp_req_ready", bif.o_req_ready, 0);
      @(negedge clk);
      check("bp_rsp_valid", bif.o_rsp_valid, 1);
      check("bp_rsp_status", bif.o_rsp_status, st);
      check("bp_rsp_data", bif.o_rsp_data, d);
    end
    bif.i_rsp_ready = 1'b1;
    check("hs_req_ready", bif.o_req_ready, 0);
    @(negedge clk);
    bif.i_rsp_ready = 1'b0;
    check("post_hs_rsp_valid", bif.o_rsp_valid, 0);
    if (hold_req) begin
      check("post_hs_no_accept", bif.o_bus_valid, 0);
      check("post_hs_req_ready", bif.o_req_ready, 1);
      bif.i_req_valid = 1'b0;
    end
  endtask

  task automatic run_txn(input logic wr, input logic [IW-1:0] idx,
                         input logic [BW-1:0] data, input logic [SW-1:0] strb,
                         input int bp_cycles, input bit hold_req,
                         output logic [1:0] st, output logic [BW-1:0] d, output int lat);
    int acc_cyc;
    log_q.delete();
    send_req(wr, idx, data, strb, acc_cyc);
    wait_rsp(acc_cyc, bp_cycles, hold_req, st, d, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]    st;
    logic [BW-1:0] d;
    int            lat;
    int            acc_cyc;
    int            n;

    bif.i_req_valid = 1'b0;
    bif.i_req_write = 1'b0;
    bif.i_req_index = '0;
    bif.i_req_data = '0;
    bif.i_req_strobe = '0;
    bif.i_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", bif.o_req_ready, 1);
    check("rst_bus_valid", bif.o_bus_valid, 0);
    check("rst_rsp_valid", bif.o_rsp_valid, 0);
    check("rst_bus_addr", bif.o_bus_address, 0);
    check("rst_bus_wdata", bif.o_bus_write_data, 0);
    check("rst_bus_strobe", bif.o_bus_strobe, 0);
    check("rst_rsp_status", bif.o_rsp_status, 0);
    check("rst_rsp_data", bif.o_rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait write idx=1
    bus_waits = 0; rd_data = 32'h5555_AAAA;
    run_txn(1'b1, 2'd1, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, st, d, lat);
    check("t1_latency", lat, 3);
    check("t1_accesses", log_q.size(), 2);
    check_acc("t1_idx", 0, 1'b1, IDX_ADDR, 32'h1, 4'hF);
    check_acc("t1_dat", 1, 1'b1, DAT_ADDR, 32'hA5A5_0F0F, 4'hF);
    check("t1_status", st, STATUS_OKAY);
    check("t1_rdata", d, 0);

    // 2: read idx=0 with 2 wait states per phase
    bus_waits = 2; rd_data = 32'h1234_5678;
    run_txn(1'b0, 2'd0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, st, d, lat);
    check("t2_latency", lat, 7);
    check("t2_accesses", log_q.size(), 2);
    check_acc("t2_idx", 0, 1'b1, IDX_ADDR, 32'h0, 4'hF);
    check_acc("t2_dat", 1, 1'b0, DAT_ADDR, 32'h0, 4'h0);
    check("t2_status", st, STATUS_OKAY);
    check("t2_rdata", d, 32'h1234_5678);

    // 3a: EXOKAY on both phases is a success; final status from data phase
    bus_waits = 0; idx_status = STATUS_EXOKAY; dat_status = STATUS_EXOKAY;
    rd_data = 32'h0BAD_F00D;
    run_txn(1'b0, 2'd2, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t3a_latency", lat, 3);
    check("t3a_accesses", log_q.size(), 2);
    check_acc("t3a_idx", 0, 1'b1, IDX_ADDR, 32'h2, 4'hF);
    check("t3a_status", st, STATUS_EXOKAY);
    check("t3a_rdata", d, 32'h0BAD_F00D);

    // 3: index write SLAVE_ERROR -> no data access, data 0
    idx_status = STATUS_SLAVE_ERROR; dat_status = STATUS_OKAY; rd_data = 32'h7777_7777;
    run_txn(1'b0, 2'd3, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t3_latency", lat, 2);
    check("t3_accesses", log_q.size(), 1);
    check_acc("t3_idx", 0, 1'b1, IDX_ADDR, 32'h3, 4'hF);
    check("t3_status", st, STATUS_SLAVE_ERROR);
    check("t3_rdata", d, 0);

    // 3b: data-phase DECODE_ERROR; index re-written after the error
    idx_status = STATUS_OKAY; dat_status = STATUS_DECODE_ERROR; rd_data = 32'hDEAD_BEEF;
    run_txn(1'b0, 2'd2, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t3b_latency", lat, 3);
    check("t3b_accesses", log_q.size(), 2);
    check("t3b_status", st, STATUS_DECODE_ERROR);
    check("t3b_rdata", d, 32'hDEAD_BEEF);

    // 4: response back-pressure 5 cycles with a next request pending
    dat_status = STATUS_OKAY; rd_data = 32'h9999_9999;
    run_txn(1'b1, 2'd3, 32'h0102_0304, 4'h5, 5, 1'b1, st, d, lat);
    check("t4_latency", lat, 3);
    check_acc("t4_idx", 0, 1'b1, IDX_ADDR, 32'h3, 4'hF);
    check_acc("t4_dat", 1, 1'b1, DAT_ADDR, 32'h0102_0304, 4'h5);
    check("t4_status", st, STATUS_OKAY);
    check("t4_rdata", d, 0);

    // 5: two reads at idx=1 back to back, then idx=0
    rd_data = 32'h1111_0001;
    run_txn(1'b0, 2'd1, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t5a_latency", lat, 3);
    check("t5a_accesses", log_q.size(), 2);
    check("t5a_rdata", d, 32'h1111_0001);
    rd_data = 32'h1111_0002;
    run_txn(1'b0, 2'd1, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t5b_latency", lat, CACHE_EN ? 2 : 3);
    check("t5b_accesses", log_q.size(), CACHE_EN ? 1 : 2);
    check_acc("t5b_dat", CACHE_EN ? 0 : 1, 1'b0, DAT_ADDR, 32'h0, 4'h0);
    check("t5b_rdata", d, 32'h1111_0002);
    rd_data = 32'h1111_0003;
    run_txn(1'b0, 2'd0, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t5c_latency", lat, 3);
    check_acc("t5c_idx", 0, 1'b1, IDX_ADDR, 32'h0, 4'hF);
    check("t5c_rdata", d, 32'h1111_0003);

    // 6: reset during DATA_ACC
    log_q.delete();
    bus_waits = 6;
    send_req(1'b0, 2'd0, 32'h0, 4'h0, acc_cyc);
    n = 0;
    while (!(bif.o_bus_valid && bif.o_bus_address == DAT_ADDR) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_data_acc", n < 50, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_bus_valid", bif.o_bus_valid, 0);
    check("t6_rsp_valid", bif.o_rsp_valid, 0);
    check("t6_req_ready", bif.o_req_ready, 1);
    check("t6_bus_addr", bif.o_bus_address, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_rsp", bif.o_rsp_valid, 0);
    bus_waits = 0; rd_data = 32'h4242_4242;
    run_txn(1'b0, 2'd0, 32'h0, 4'h0, 0, 1'b0, st, d, lat);
    check("t6_post_latency", lat, 3);
    check("t6_post_accesses", log_q.size(), 2);
    check_acc("t6_post_idx", 0, 1'b1, IDX_ADDR, 32'h0, 4'hF);
    check("t6_post_rdata", d, 32'h4242_4242);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
